// File: rtl/ama_riscv_icache_resp_pkg.sv
// ----------------------------------------------------------------------------
// ama_riscv_icache_resp_pkg
// Shared definitions for the instruction cache responder: the FSM state type,
// the line/word geometry and the helpers that derive index and tag widths
// from the number of sets.
// ----------------------------------------------------------------------------
package ama_riscv_icache_resp_pkg;

    localparam int IC_ADDR_W     = 32;                        // byte address width
    localparam int IC_WORD_W     = 32;                        // instruction width
    localparam int IC_LINE_W     = 128;                       // one cache line
    localparam int IC_OFF_W      = 2;                         // word offset within a line
    localparam int IC_BYTE_W     = 2;                         // byte offset within a word (ignored)
    localparam int IC_LINE_OFF_W = IC_OFF_W + IC_BYTE_W;      // low bits below the index

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MISS_REQ   = 2'd1,
        MISS_WAIT  = 2'd2,
        REFILL_RSP = 2'd3
    } icache_state_t;

    // Index width for a power-of-two number of sets.
    function automatic int ic_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: everything above the index.
    function automatic int ic_tag_w(input int sets);
        return IC_ADDR_W - IC_LINE_OFF_W - $clog2(sets);
    endfunction

    // Pick one 32-bit word out of a line; word 0 sits in bits [31:0].
    function automatic logic [IC_WORD_W-1:0] ic_word_sel(
        input logic [IC_LINE_W-1:0] line,
        input logic [IC_OFF_W-1:0]  off
    );
        return line[{off, 5'b0} +: IC_WORD_W];
    endfunction

endpackage

// File: rtl/ama_riscv_icache_array.sv
// ----------------------------------------------------------------------------
// ama_riscv_icache_array
// Direct-mapped storage for the instruction cache: a valid bit, a tag and a
// 128-bit data line per set.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_en, rd_idx       synchronous read request; result appears next cycle
//   rd_valid/tag/line   registered read result, held while rd_en is low
//   wr_en, wr_idx       line write (tag, data, and valid set)
//   wr_tag, wr_line     write payload
//   clr                 clear every valid bit; wins over a same-cycle write
// ----------------------------------------------------------------------------
module ama_riscv_icache_array
    import ama_riscv_icache_resp_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = ic_idx_w(SETS),
    parameter int TAG_W = ic_tag_w(SETS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [IC_LINE_W-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [IC_LINE_W-1:0] wr_line,
    input  logic                 clr
);

    logic [SETS-1:0]      valid_q;
    logic [TAG_W-1:0]     tag_mem  [SETS];
    logic [IC_LINE_W-1:0] data_mem [SETS];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are plain RAM with no reset; the valid bits
    // alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

    // The read result is registered at the accept edge, so a clear arriving
    // during the compare cycle does not disturb the lookup in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_tag   <= '0;
            rd_line  <= '0;
        end else if (rd_en) begin
            rd_valid <= valid_q[rd_idx];
            rd_tag   <= tag_mem[rd_idx];
            rd_line  <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/ama_riscv_icache_resp.sv
// ----------------------------------------------------------------------------
// ama_riscv_icache_resp
// Responder end of the instruction fetch interface. A direct-mapped,
// read-only cache answers one 32-bit instruction per request; misses are
// refilled one line at a time over a ready/valid backing-memory handshake.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   imem_req_valid/ready/data         fetch byte address from the front end
//   imem_rsp_valid/ready/data         instruction back to the front end
//   mem_req_valid/ready/data          line-aligned refill address
//   mem_rsp_valid/ready/data          refill line, word 0 in bits [31:0]
//   inv                               invalidate-all pulse (fence.i)
//   hit_cnt, miss_cnt                 free-running lookup counters
// ----------------------------------------------------------------------------
module ama_riscv_icache_resp
    import ama_riscv_icache_resp_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // fetch request from the front end
    input  logic                         imem_req_valid,
    output logic                         imem_req_ready,
    input  logic [IC_ADDR_W-1:0]         imem_req_data,
    // instruction response to the front end
    output logic                         imem_rsp_valid,
    input  logic                         imem_rsp_ready,
    output logic [IC_WORD_W-1:0]         imem_rsp_data,
    // refill request to backing memory
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [IC_ADDR_W-1:0]         mem_req_data,
    // refill line from backing memory
    input  logic                         mem_rsp_valid,
    output logic                         mem_rsp_ready,
    input  logic [LINE_WORDS*32-1:0]     mem_rsp_data,
    // control and statistics
    input  logic                         inv,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
);

    localparam int IDX_W = ic_idx_w(SETS);
    localparam int TAG_W = ic_tag_w(SETS);

    icache_state_t                      state;
    logic                               lookup_q;  // compare cycle of an accepted request
    logic                               hold_q;    // hit response stalled by the front end
    logic [IC_ADDR_W-1:IC_BYTE_W]       req_addr;  // word address of the request in flight
    logic [IC_LINE_W-1:0]               line_q;    // refill line kept for the REFILL_RSP reply

    logic                               rd_valid;
    logic [TAG_W-1:0]                   rd_tag;
    logic [IC_LINE_W-1:0]               rd_line;

    logic                               req_fire;
    logic                               fill_fire;
    logic                               lookup_hit;
    logic                               lookup_miss;

    logic [IC_OFF_W-1:0]                req_off;
    logic [IDX_W-1:0]                   req_idx;
    logic [TAG_W-1:0]                   req_tag;

    // Byte-within-word bits of the fetch address carry no information here.
    logic unused_byte_off;
    assign unused_byte_off = ^imem_req_data[IC_BYTE_W-1:0];

    assign req_off = req_addr[IC_LINE_OFF_W-1 -: IC_OFF_W];
    assign req_idx = req_addr[IC_LINE_OFF_W +: IDX_W];
    assign req_tag = req_addr[IC_ADDR_W-1 -: TAG_W];

    assign mem_req_data = {req_addr[IC_ADDR_W-1:IC_LINE_OFF_W], {IC_LINE_OFF_W{1'b0}}};

    // ------------------------------------------------------------------
    // Lookup and front-end handshake
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        lookup_hit     = 1'b0;
        lookup_miss    = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = ic_word_sel(rd_line, req_off);
        imem_req_ready = 1'b0;

        lookup_hit  = lookup_q && rd_valid && (rd_tag == req_tag);
        lookup_miss = lookup_q && !lookup_hit;

        if (state == REFILL_RSP) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ic_word_sel(line_q, req_off);
        end else if (state == IDLE) begin
            imem_rsp_valid = lookup_hit || hold_q;
        end

        // A miss closes the door in its compare cycle; a stalled response
        // keeps it closed until the front end takes the data.
        imem_req_ready = (state == IDLE) && !lookup_miss &&
                         (!imem_rsp_valid || imem_rsp_ready);
    end

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign fill_fire = (state == MISS_WAIT) && mem_rsp_valid && mem_rsp_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    ama_riscv_icache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (req_fire),
        .rd_idx   (imem_req_data[IC_LINE_OFF_W +: IDX_W]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (fill_fire),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_line  (mem_rsp_data),
        .clr      (inv)
    );

    // ------------------------------------------------------------------
    // FSM, request register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            lookup_q      <= 1'b0;
            hold_q        <= 1'b0;
            req_addr      <= '0;
            line_q        <= '0;
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            lookup_q <= req_fire;
            if (req_fire) begin
                req_addr <= imem_req_data[IC_ADDR_W-1:IC_BYTE_W];
            end

            unique case (state)
                IDLE: begin
                    // Counting happens only in the compare cycle, so a
                    // stalled hit is counted once however long it waits.
                    if (lookup_hit) begin
                        hit_cnt <= hit_cnt + 32'd1;
                        hold_q  <= !imem_rsp_ready;
                    end else if (hold_q && imem_rsp_ready) begin
                        hold_q <= 1'b0;
                    end
                    if (lookup_miss) begin
                        miss_cnt      <= miss_cnt + 32'd1;
                        mem_req_valid <= 1'b1;
                        state         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_rsp_ready <= 1'b1;
                        state         <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_rsp_valid) begin
                        line_q        <= mem_rsp_data;
                        mem_rsp_ready <= 1'b0;
                        state         <= REFILL_RSP;
                    end
                end
                REFILL_RSP: begin
                    if (imem_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ama_riscv_icache_resp.sv
// ----------------------------------------------------------------------------
// tb_ama_riscv_icache_resp
// Directed bench for the instruction cache responder. A behavioural backing
// memory returns, for a line at byte address B, words (B>>2)+1 .. (B>>2)+4.
// ----------------------------------------------------------------------------
module tb_ama_riscv_icache_resp;

    logic         clk;
    logic         rst;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_data;
    logic         imem_rsp_valid;
    logic         imem_rsp_ready;
    logic [31:0]  imem_rsp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_data;
    logic         mem_rsp_valid;
    logic         mem_rsp_ready;
    logic [127:0] mem_rsp_data;
    logic         inv;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int total = 0;
    int bad   = 0;

    // memory model controls and observations
    int          mem_lat    = 3;
    bit          inv_on_rsp = 1'b0;
    int          mreq_count = 0;
    logic [31:0] mreq_last  = '0;

    ama_riscv_icache_resp #(
        .SETS       (16),
        .LINE_WORDS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_data  (imem_req_data),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_data   (mem_req_data),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rsp_data   (mem_rsp_data),
        .inv            (inv),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] base);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = (base >> 2) + 32'(w) + 32'd1;
        end
        return l;
    endfunction

    // Backing memory: accepts every request at once, answers mem_lat cycles
    // after the request handshake, and abandons the answer on reset.
    initial begin : mem_model
        logic [31:0] base;
        bit          live;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        inv           = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && mem_req_valid && mem_req_ready) begin
                base = mem_req_data;
                mreq_count++;
                mreq_last = base;
                @(posedge clk);
                live = 1'b1;
                for (int i = 1; i < mem_lat; i++) begin
                    @(posedge clk);
                    if (!rst) live = 1'b0;
                end
                if (live && rst) begin
                    #1;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = line_of(base);
                    if (inv_on_rsp) inv = 1'b1;
                    for (int i = 0; i < 50; i++) begin
                        @(negedge clk);
                        if (mem_rsp_ready || !rst) break;
                    end
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b0;
                    inv           = 1'b0;
                end
            end
        end
    end

    // One fetch: present the address, wait for acceptance, then wait for the
    // response. lat counts cycles from the accept edge to the response.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                         output int lat, output bit ok);
        int n;
        d   = '0;
        lat = -1;
        ok  = 1'b0;
        @(posedge clk);
        #1;
        imem_req_valid = 1'b1;
        imem_req_data  = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req_ready && n < 50);
        if (!imem_req_ready) begin
            imem_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        imem_req_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (imem_rsp_valid) begin
                d  = imem_rsp_data;
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          miss;
        int          hits;
        int          misses;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        logic [31:0] d;
        int          lat;
        bit          ok;
        int          m0;
        int          n;

        vecs[0] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 0, 1};
        vecs[1] = '{32'h0000_0004, 32'h0000_0002, 1'b0, 1, 1};
        vecs[2] = '{32'h0000_0008, 32'h0000_0003, 1'b0, 2, 1};
        vecs[3] = '{32'h0000_000C, 32'h0000_0004, 1'b0, 3, 1};
        vecs[4] = '{32'h0000_0100, 32'h0000_0041, 1'b1, 3, 2};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 3, 3};
        vecs[6] = '{32'h0000_010C, 32'h0000_0044, 1'b1, 3, 4};
        vecs[7] = '{32'h0000_0013, 32'h0000_0005, 1'b1, 3, 5};
        vecs[8] = '{32'h0000_001F, 32'h0000_0008, 1'b0, 4, 5};
        vecs[9] = '{32'hFFF0_0008, 32'h3FFC_0003, 1'b1, 4, 6};

        rst            = 1'b0;
        imem_req_valid = 1'b0;
        imem_req_data  = '0;
        imem_rsp_ready = 1'b1;

        // ---------------- reset values ----------------
        #12;
        check("rst imem_req_ready", {31'b0, imem_req_ready}, 32'd1);
        check("rst imem_rsp_valid", {31'b0, imem_rsp_valid}, 32'd0);
        check("rst imem_rsp_data",  imem_rsp_data, 32'd0);
        check("rst mem_req_valid",  {31'b0, mem_req_valid}, 32'd0);
        check("rst mem_rsp_ready",  {31'b0, mem_rsp_ready}, 32'd0);
        check("rst hit_cnt",        hit_cnt, 32'd0);
        check("rst miss_cnt",       miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ---------------- table: single fetches ----------------
        for (int i = 0; i < 10; i++) begin
            m0 = mreq_count;
            fetch(vecs[i].addr, d, lat, ok);
            check($sformatf("row%0d rsp seen", i), {31'b0, ok}, 32'd1);
            check($sformatf("row%0d data", i), d, vecs[i].data);
            check($sformatf("row%0d latency", i), 32'(lat), vecs[i].miss ? 32'd6 : 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("row%0d hit_cnt", i), hit_cnt, 32'(vecs[i].hits));
            check($sformatf("row%0d miss_cnt", i), miss_cnt, 32'(vecs[i].misses));
            check($sformatf("row%0d mem_req count", i), 32'(mreq_count - m0),
                  vecs[i].miss ? 32'd1 : 32'd0);
            if (vecs[i].miss)
                check($sformatf("row%0d mem_req addr", i), mreq_last,
                      vecs[i].addr & 32'hFFFF_FFF0);
        end

        // ---------------- back-to-back hits on line 0x10 ----------------
        m0 = mreq_count;
        @(posedge clk);
        #1;
        imem_req_valid = 1'b1;
        imem_req_data  = 32'h10;
        @(negedge clk);
        check("b2b accept0", {31'b0, imem_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        imem_req_data = 32'h14;
        @(negedge clk);
        check("b2b valid0", {31'b0, imem_rsp_valid}, 32'd1);
        check("b2b data0", imem_rsp_data, 32'h5);
        check("b2b accept1", {31'b0, imem_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        imem_req_data = 32'h18;
        @(negedge clk);
        check("b2b valid1", {31'b0, imem_rsp_valid}, 32'd1);
        check("b2b data1", imem_rsp_data, 32'h6);
        @(posedge clk);
        #1;
        imem_req_valid = 1'b0;
        @(negedge clk);
        check("b2b valid2", {31'b0, imem_rsp_valid}, 32'd1);
        check("b2b data2", imem_rsp_data, 32'h7);
        @(posedge clk);
        #1;
        check("b2b hit_cnt", hit_cnt, 32'd7);
        check("b2b no mem_req", 32'(mreq_count - m0), 32'd0);

        // ---------------- stalled hit response ----------------
        imem_rsp_ready = 1'b0;
        imem_req_valid = 1'b1;
        imem_req_data  = 32'h14;
        @(negedge clk);
        check("hold accept", {31'b0, imem_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        imem_req_data = 32'h18;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d valid", k), {31'b0, imem_rsp_valid}, 32'd1);
            check($sformatf("hold%0d data", k), imem_rsp_data, 32'h6);
            check($sformatf("hold%0d req_ready", k), {31'b0, imem_req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        imem_rsp_ready = 1'b1;
        @(negedge clk);
        check("hold release data", imem_rsp_data, 32'h6);
        check("hold release req_ready", {31'b0, imem_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        imem_req_valid = 1'b0;
        @(negedge clk);
        check("hold next valid", {31'b0, imem_rsp_valid}, 32'd1);
        check("hold next data", imem_rsp_data, 32'h7);
        @(posedge clk);
        #1;
        check("hold hit_cnt", hit_cnt, 32'd9);

        // ---------------- inv during the refill handshake ----------------
        inv_on_rsp = 1'b1;
        fetch(32'h200, d, lat, ok);
        inv_on_rsp = 1'b0;
        check("inv rsp seen", {31'b0, ok}, 32'd1);
        check("inv data", d, 32'h81);
        check("inv latency", 32'(lat), 32'd6);
        fetch(32'h204, d, lat, ok);
        check("inv refetch data", d, 32'h82);
        check("inv refetch misses", 32'(lat), 32'd6);
        fetch(32'h1C, d, lat, ok);
        check("inv other line data", d, 32'h8);
        check("inv other line misses", 32'(lat), 32'd6);
        @(posedge clk);
        #1;
        check("inv miss_cnt", miss_cnt, 32'd9);

        // ---------------- reset during MISS_WAIT ----------------
        mem_lat = 5;
        @(posedge clk);
        #1;
        imem_req_valid = 1'b1;
        imem_req_data  = 32'h30;
        @(negedge clk);
        check("rstw accept", {31'b0, imem_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        imem_req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstw mem_req seen", {31'b0, mem_req_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rstw in MISS_WAIT", {31'b0, mem_rsp_ready}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rstw mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rstw mem_rsp_ready", {31'b0, mem_rsp_ready}, 32'd0);
        check("rstw imem_req_ready", {31'b0, imem_req_ready}, 32'd1);
        check("rstw hit_cnt", hit_cnt, 32'd0);
        check("rstw miss_cnt", miss_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        mem_lat = 3;
        repeat (8) @(posedge clk);
        fetch(32'h14, d, lat, ok);
        check("rstw refetch data", d, 32'h6);
        check("rstw refetch misses", 32'(lat), 32'd6);
        @(posedge clk);
        #1;
        check("rstw refetch miss_cnt", miss_cnt, 32'd1);
        check("rstw refetch hit_cnt", hit_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ama_riscv_icache_resp.md
# ama_riscv_icache_resp

Responder end of the front-end instruction fetch interface: accepts fetch requests on `imem_req`, returns one 32-bit instruction per request on `imem_rsp`. Internally a direct-mapped, read-only instruction cache with a single-outstanding line refill over a backing-memory handshake. It sits between the front-end controller and the memory subsystem. It signals a miss to the controller by dropping `imem_req.ready`.

## Interface
- `SETS`, 16: number of cache lines; must be a power of 2 and at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; fixed at 4 in this revision (128-bit line).
- `clk` input 1: the single clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `imem_req` rv_if.RX, data 32: fetch byte address from the front end.
- `imem_rsp` rv_if.TX, data 32: instruction returned to the front end.
- `mem_req` rv_if.TX, data 32: line-aligned refill address sent to backing memory.
- `mem_rsp` rv_if.RX, data 128: refill line. Word 0 is in bits [31:0].
- `inv` input 1: invalidate-all pulse, used for fence.i.
- `hit_cnt` output 32: count of hits; wraps at 2^32.
- `miss_cnt` output 32: count of misses; wraps at 2^32.

## Operation
- Address split:
  - offset = addr[3:2]
  - index = addr[3+log2(SETS):4]
  - tag = remaining upper bits
  - addr[1:0] is ignored.
- Per-set storage: valid bit, tag, 128-bit data line.
- States:
  - IDLE: reset state.
  - MISS_REQ
  - MISS_WAIT
  - REFILL_RSP
- IDLE behaviour:
  - `imem_req.ready` = !rsp_pending || `imem_rsp.ready`.
  - An accepted request is registered. Storage is read the same cycle, and the tag is compared the next cycle.
- Hit: `imem_rsp.valid`=1 with the word at offset. `hit_cnt`++. State stays IDLE. Back-to-back hits are allowed.
- Miss:
  - `imem_rsp.valid`=0 and `imem_req.ready`=0. `miss_cnt`++. Go to MISS_REQ.
  - MISS_REQ: `mem_req.valid`=1, data = {addr[31:4], 4'b0}. On handshake, go to MISS_WAIT.
  - MISS_WAIT: `mem_rsp.ready`=1. On handshake, write data, tag and valid=1, capture the line, go to REFILL_RSP.
  - REFILL_RSP: `imem_rsp.valid`=1 with the requested word from the captured line. On `imem_rsp.ready`, go to IDLE.
- Response hold: while `imem_rsp.valid` && !`imem_rsp.ready`, the response data stays stable and no new request is accepted.
- `inv`:
  - Clears all valid bits on the next edge, in any state.
  - If a refill write occurs in the same cycle, the valid set is suppressed (`inv` wins). The pending response is still delivered.
  - If `inv` is asserted in IDLE in the same cycle as a lookup, the lookup result uses the pre-`inv` valid bits.
- Reset:
  - Asserting reset mid-operation returns to IDLE immediately and drops `mem_req.valid`.
  - Backing memory shares the same reset, so no stale `mem_rsp` is expected.

## Timing
- Reset values:
  - `imem_req.ready`=1
  - `imem_rsp.valid`=0, `imem_rsp.data`=0
  - `mem_req.valid`=0, `mem_rsp.ready`=0
  - `hit_cnt`=0, `miss_cnt`=0
  - all valid bits 0
- Hit latency: request accepted in cycle N; `imem_rsp.valid` in N+1.
- Miss latency: accepted in N; miss seen in N+1; `mem_req.valid` from N+2. With mem_req handshake at cycle A and mem_rsp handshake at cycle B (B ≥ A+1), `imem_rsp.valid` is asserted at B+1.
- `imem_req.ready` is low from N+1 through the cycle `imem_rsp` handshakes in REFILL_RSP.
- Counters update on the edge ending the compare cycle.
- A request whose address falls in a line being refilled cannot occur, because the cache is single-outstanding.

## Structure
- Shared defines package holds:
  - `icache_state_t`
  - `IC_LINE_W` = 128
  - `IC_OFF_W` = 2
  - derived index/tag width helpers.
- One sub-module: `ama_riscv_icache_array`, holding valid, tag and data storage. It has a synchronous read, a write port, and a clear-all.
- The FSM, request register and counters stay in the top-level module.

## Test plan
- Cold fetch after reset to 0x0000_0000, memory returns line {0x4,0x3,0x2,0x1} after 3 cycles. Expect:
  - one `mem_req` with addr 0x0
  - `imem_rsp` = 0x1
  - `miss_cnt`=1
- Then fetch 0x4, 0x8, 0xC back-to-back. Expect:
  - responses 0x2, 0x3, 0x4 in consecutive cycles
  - `hit_cnt`=3
  - no `mem_req`.
- Conflict: fetch 0x0 then 0x100 (same index, SETS=16). Expect a second refill. A fetch of 0x0 afterwards misses again; `miss_cnt`=3.
- Hold `imem_rsp.ready`=0 for 4 cycles on a hit. Expect:
  - data stable
  - `imem_req.ready`=0
  - no new accept until ready rises.
- Pulse `inv` in the same cycle as the MISS_WAIT handshake. Expect:
  - the response is still delivered
  - a subsequent fetch to the same line misses.
- Assert reset during MISS_WAIT. Expect:
  - `mem_req.valid`=0 and `imem_req.ready`=1 immediately
  - counters cleared
  - the next fetch misses.
